// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic controller:
// state codes, lamp encodings and the lamp decode used by the FSM output stage.
package traffic_pkg;

    localparam logic [2:0] MG  = 3'd0;
    localparam logic [2:0] MY  = 3'd1;
    localparam logic [2:0] AR1 = 3'd2;
    localparam logic [2:0] SG  = 3'd3;
    localparam logic [2:0] SY  = 3'd4;
    localparam logic [2:0] AR2 = 3'd5;
    localparam logic [2:0] EM  = 3'd6;

    // Lamp triplets are {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef struct packed {
        logic [2:0] main_lamp;
        logic [2:0] side_lamp;
    } lights_t;

    function automatic lights_t light_decode(input logic [2:0] st);
        lights_t l;
        l.main_lamp = RED;
        l.side_lamp = RED;
        case (st)
            MG: l.main_lamp = GRN;
            MY: l.main_lamp = YEL;
            SG: l.side_lamp = GRN;
            SY: l.side_lamp = YEL;
            default: ;
        endcase
        return l;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/traffic_fsm_tick_timer.sv
// Tick-counting phase timer. Counts tick strobes up to limit-1 and saturates there;
// done fires on the tick that completes the phase.
module tick_timer #(
    parameter int TW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          tick,
    input  logic [TW-1:0] limit,
    output logic          done
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;
    logic          at_limit;

    assign at_limit = (count_q == (limit - TW'(1)));
    assign done     = tick & at_limit;

    // Clear dominates, so a tick landing on a state change is never counted.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && !at_limit) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_fsm.sv
// Two-road traffic-light controller: main road green by default, side road served
// with a green/yellow/all-red cycle after a latched request and main minimum green.
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 4,
    parameter int YELLOW     = 2,
    parameter int CLEAR      = 1,
    parameter int SIDE_GREEN = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       emerg,
    input  logic       tick,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic [2:0] state_o,
    output logic       req_ack
);

    localparam int TW = $clog2(max4(MIN_GREEN, YELLOW, CLEAR, SIDE_GREEN)) + 1;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic          pending_q;
    logic          pending_d;
    logic          req_ack_q;
    logic          req_ack_d;
    logic [TW-1:0] limit;
    logic          timer_clear;
    logic          timer_done;
    lights_t       lights;

    // Phase length for the state currently held; EM has no duration of its own.
    always_comb begin
        limit = TW'(1);
        case (state_q)
            MG:       limit = TW'(MIN_GREEN);
            MY, SY:   limit = TW'(YELLOW);
            AR1, AR2: limit = TW'(CLEAR);
            SG:       limit = TW'(SIDE_GREEN);
            default:  limit = TW'(1);
        endcase
    end

    tick_timer #(
        .TW(TW)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .clear(timer_clear),
        .tick (tick),
        .limit(limit),
        .done (timer_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= MG;
            pending_q <= 1'b0;
            req_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_ack_q <= req_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (emerg) begin
            state_d = EM;
        end else begin
            case (state_q)
                MG:  if (timer_done && (pending_q || req)) state_d = MY;
                MY:  if (timer_done) state_d = AR1;
                AR1: if (timer_done) state_d = SG;
                SG:  if (timer_done) state_d = SY;
                SY:  if (timer_done) state_d = AR2;
                AR2: if (timer_done) state_d = MG;
                EM:  state_d = AR2;
                default: state_d = MG;
            endcase
        end
    end

    // Entering SG consumes the request; that clear beats a same-cycle req.
    always_comb begin
        timer_clear = (state_d != state_q);
        req_ack_d   = (state_d == SG) && (state_q != SG);
        pending_d   = pending_q;
        if (req_ack_d) begin
            pending_d = 1'b0;
        end else if (req) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        lights  = light_decode(state_q);
        main_lt = lights.main_lamp;
        side_lt = lights.side_lamp;
        state_o = state_q;
        req_ack = req_ack_q;
    end

    // Conflicting greens/yellows across roads must never be shown.
    a_no_conflict: assert property (@(posedge clock) disable iff (reset)
        !((main_lt[1:0] != 2'b00) && (side_lt[1:0] != 2'b00)));

endmodule
